// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data requests onto one single-port memory,
// data first with a starvation guard for instruction fetch, one transaction in flight.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_kill,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy
);
    localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic          own_i_q, own_i_d, we_q, we_d, kill_q, kill_d;
    logic          i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [3:0]    be_q, be_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          sel_i, accept, ret;

    always_comb begin
        state_d  = state_q;
        own_i_d  = own_i_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        starve_d = starve_q;
        sel_i    = i_req && (!d_req || starve_q == LIM);
        accept   = state_q == ISSUE && m_ready;
        ret      = state_q == RESP && m_rvalid;
        if (state_q == IDLE && (i_req || d_req)) begin
            state_d  = ISSUE;
            own_i_d  = sel_i;
            we_d     = sel_i ? 1'b0 : d_we;
            addr_d   = sel_i ? i_addr : d_addr;
            wdata_d  = sel_i ? 32'h0 : d_wdata;
            be_d     = sel_i ? 4'hf : d_be;
            starve_d = (sel_i || !i_req) ? '0 : (starve_q == LIM) ? starve_q : starve_q + 1'b1;
        end else if (accept) begin
            state_d = we_q ? IDLE : RESP;
        end else if (ret) begin
            state_d = IDLE;
        end
        // a kill seen in the returning cycle itself must still suppress the response
        kill_d     = state_q != IDLE && state_d != IDLE && own_i_q && (kill_q || i_kill);
        i_rvalid_d = ret && own_i_q && !kill_q && !i_kill;
        d_rvalid_d = ret && !own_i_q;
        i_rdata_d  = i_rvalid_d ? m_rdata : i_rdata_q;
        d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            own_i_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            starve_q   <= '0;
            kill_q     <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            own_i_q    <= own_i_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            starve_q   <= starve_d;
            kill_q     <= kill_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign m_req    = state_q == ISSUE;
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_be     = be_q;
    assign i_gnt    = accept && own_i_q;
    assign d_gnt    = accept && !own_i_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = state_q != IDLE;
endmodule
